alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single RV32I ALU between `NUM_REQ` requesters, such as the core datapath, the address-generation path and the debug/test port. Each cycle it grants at most one requester round-robin and drives the shared ALU operands and 4-bit control. It captures the ALU result and zero flag in that requester's private response slot. The slot holds the result under a valid/ready handshake until the requester consumes it.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..4.
- `DATA_W`, default 32: operand/result width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in NUM_REQ: request present, one bit per requester.
- `req_ready` out NUM_REQ: grant; the request is accepted when valid & ready.
- `req_ctrl` in 4*NUM_REQ: ALUControl per requester (0000 ADD … 1001 SRA).
- `req_a` in DATA_W*NUM_REQ: operand A per requester.
- `req_b` in DATA_W*NUM_REQ: operand B per requester.
- `req_lock` in NUM_REQ: hold priority after an accepted request; used only with `ALU_ARB_LOCK_EN`.
- `resp_valid` out NUM_REQ: response slot full.
- `resp_ready` in NUM_REQ: requester consumes its slot.
- `resp_data` out DATA_W*NUM_REQ: captured ALU result per slot.
- `resp_zero` out NUM_REQ: captured ALU zero flag per slot.
- `alu_a` out DATA_W: shared ALU operand A.
- `alu_b` out DATA_W: shared ALU operand B.
- `alu_ctrl` out 4: shared ALU control.
- `alu_result` in DATA_W: result from the combinational ALU.
- `alu_zero` in 1: zero flag from the combinational ALU.
- `grant_id` out 2: index of the current grantee; valid only while `|req_ready`.

## Operation
- Eligibility: `elig[i] = req_valid[i] & (~resp_valid[i] | resp_ready[i])`.
  - A requester whose slot is full and not being consumed this cycle is masked.
- Round-robin pointer `rr_ptr` (clog2 NUM_REQ bits) names the highest-priority requester.
  - Search order: rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - At most one `req_ready` bit is high, and it is combinational from `elig` and `rr_ptr`.
  - No request may wait more than NUM_REQ-1 grants.
- Pointer update happens only on an accepted request: `rr_ptr <= grant_id+1`, wrapping from NUM_REQ-1 to 0. With no grant, `rr_ptr` holds.
- Shared ALU drive while granted: `alu_a/alu_b/alu_ctrl` = grantee's `req_a/req_b/req_ctrl`.
- Shared ALU drive while idle: `alu_a=0`, `alu_b=0`, `alu_ctrl=0000` (ADD), `grant_id=0`.
- Each response slot is a 2-state FSM:
  - EMPTY→FULL on an accepted request: latch `alu_result` and `alu_zero`.
  - FULL→EMPTY on `resp_ready` with no new grant to the same requester.
  - FULL→FULL (reload) on `resp_ready` plus a new grant in the same cycle.
  - `resp_ready` while EMPTY is ignored.
- Slot data is stable while FULL and is updated only on a reload.
- No arithmetic inside the block. Widths pass through unchanged, and ALUControl codes are not checked (unknown codes go to the ALU as-is).

## Timing
- Reset values: `rr_ptr=0`, all `resp_valid=0`, `resp_data=0`, `resp_zero=0`.
  - Outputs while in reset: `req_ready=0`, ALU outputs at idle values.
- Latency: request accepted in cycle N; `resp_valid` is high and data visible in cycle N+1.
- Throughput:
  - One operation per cycle overall.
  - One per cycle per requester if it asserts `resp_ready` every cycle.
- Simultaneous request from all requesters: grants rotate in pointer order, one per cycle.
- Mid-operation reset: every slot is emptied immediately and asynchronously, pending results are discarded, and the pointer returns to 0.
- `req_*` inputs are held by the requester until accepted; an unaccepted request may change or drop.

## Configuration
- `ALU_ARB_LOCK_EN` defined:
  - If the accepted request also has `req_lock[i]=1`, `rr_ptr <= i` rather than i+1.
  - Requester i therefore keeps top priority for back-to-back ops, e.g. a multi-step address sequence.
  - Lock is released by the first accepted request with `req_lock=0`.
- `ALU_ARB_LOCK_EN` undefined: the `req_lock` port exists but is ignored, giving pure round-robin.

## Test plan
- Reset mid-traffic: assert `rst` with slots 0 and 1 full → `resp_valid=00`, `rr_ptr=0`, `alu_ctrl=0000` at once. First grant after release goes to requester 0.
- Single requester: req0 ADD 5+7, `alu_result=12` from a model ALU → `req_ready=01` in cycle N. Cycle N+1 shows `resp_valid[0]=1`, `resp_data0=12`, `resp_zero0=0`.
- Contention: both valid continuously, both `resp_ready=1` → grants alternate 0,1,0,1 and each result lands in the matching slot.
- Backpressure: req0 SUB 3-3 completes with `resp_ready0=0` (`resp_zero0=1`). A new req0 is masked while req1 is granted every cycle. Raising `resp_ready0` gives a same-cycle reload with `resp_valid0` staying 1.
- Idle: no `req_valid` → `req_ready=00`, `alu_a=alu_b=0`, `alu_ctrl=0000`, and `rr_ptr` unchanged.
- Lock (`ALU_ARB_LOCK_EN` defined): req1 with `req_lock=1` for 3 ops while req0 is valid → grants 1,1,1, then 0 after the lock drops. Without the macro the same stimulus gives 1,0,1,0.

Source files
------------

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational RV32I ALU between NUM_REQ requesters. Each cycle
// at most one eligible requester is granted in round-robin order. Its
// operands and 4-bit ALUControl are steered onto the shared ALU. The ALU
// result and zero flag are captured into that requester's private response
// slot on the same clock edge. A slot stays FULL, with stable contents,
// until its owner consumes it with resp_ready.
//
// Optional feature (compile-time macro ALU_ARB_LOCK_EN):
//   When defined, an accepted request with req_lock[i]=1 leaves the
//   round-robin pointer on i, so requester i keeps top priority for
//   back-to-back operations. When undefined, req_lock is ignored and
//   arbitration is pure round-robin.
//
// Parameters:
//   NUM_REQ    number of requesters (2..4)
//   DATA_W     operand / result width
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake, one bit per requester
//                       (req_ready is the one-hot grant)
//   req_ctrl            4-bit ALUControl per requester, packed
//   req_a, req_b        operands per requester, packed DATA_W slices
//   req_lock            priority hold request (ALU_ARB_LOCK_EN only)
//   resp_valid/ready    response slot handshake per requester
//   resp_data/zero      captured ALU result / zero flag per slot
//   alu_a/alu_b/ctrl    shared ALU drive (zero / ADD when idle)
//   alu_result/zero     shared ALU outputs
//   grant_id            index of current grantee (0 when no grant)
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [4*NUM_REQ-1:0]      req_ctrl,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W*NUM_REQ-1:0] resp_data,
  output logic [NUM_REQ-1:0]        resp_zero,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [3:0]                alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic [1:0]                grant_id
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t          slot_state [NUM_REQ];
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     ptr_next;
  logic [NUM_REQ-1:0]   elig;
  logic                 grant_any;
  logic [PTR_W-1:0]     grant_idx;

  // A full slot that is not being drained this cycle has nowhere to put a
  // new result, so its owner sits out arbitration.
  assign elig = req_valid & (~resp_valid | resp_ready);

  // -------------------------------------------------------------------------
  // Round-robin search starting at rr_ptr. The grant is purely combinational
  // so the request is accepted and its result captured in the same cycle.
  // Reset suppresses any grant so nothing is accepted while rst is high.
  // -------------------------------------------------------------------------
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    cand      = 0;
    cand_idx  = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!grant_any && !rst && elig[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign grant_id = grant_any ? 2'(grant_idx) : 2'b00;

  // Shared ALU drive: grantee's operands, or ADD 0+0 when idle so the ALU
  // inputs are quiet and deterministic.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = 4'b0000;
    if (grant_any) begin
      alu_a    = req_a[int'(grant_idx)*DATA_W +: DATA_W];
      alu_b    = req_b[int'(grant_idx)*DATA_W +: DATA_W];
      alu_ctrl = req_ctrl[int'(grant_idx)*4 +: 4];
    end
  end

  // -------------------------------------------------------------------------
  // Pointer update: advance past the grantee, or stay on it while it holds
  // the lock. No grant, no movement.
  // -------------------------------------------------------------------------
  always_comb begin
    ptr_next = rr_ptr;
    if (grant_any) begin
      if (int'(grant_idx) == NUM_REQ - 1) ptr_next = '0;
      else                                ptr_next = PTR_W'(int'(grant_idx) + 1);
`ifdef ALU_ARB_LOCK_EN
      if (req_lock[grant_idx]) ptr_next = grant_idx;
`endif
    end
  end

`ifndef ALU_ARB_LOCK_EN
  // Lock input exists on the port list in every build; without the feature
  // it is deliberately left without effect.
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // -------------------------------------------------------------------------
  // Response slots. A grant to requester i always means its slot is empty or
  // being drained this cycle, so an accepted request always writes the slot
  // (EMPTY->FULL or FULL->FULL reload). Otherwise a drain empties it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      // NOTE: the result storage is reset as well because its reset value
      // (zero) is architecturally visible on resp_data; plain data storage
      // that is never observed before being written would not need it.
      resp_data <= '0;
      resp_zero <= '0;
      for (int i = 0; i < NUM_REQ; i++) slot_state[i] <= SLOT_EMPTY;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      rr_ptr <= ptr_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        case (slot_state[i])
          SLOT_EMPTY: begin
            if (req_ready[i]) begin
              slot_state[i]                    <= SLOT_FULL;
              resp_data[i*DATA_W +: DATA_W]    <= alu_result;
              resp_zero[i]                     <= alu_zero;
            end
          end
          SLOT_FULL: begin
            if (req_ready[i]) begin
              resp_data[i*DATA_W +: DATA_W]    <= alu_result;
              resp_zero[i]                     <= alu_zero;
            end else if (resp_ready[i]) begin
              slot_state[i] <= SLOT_EMPTY;
            end
          end
          default: slot_state[i] <= SLOT_EMPTY;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) resp_valid[i] = (slot_state[i] == SLOT_FULL);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter with NUM_REQ=2, DATA_W=32. A model
// RV32I ALU answers the shared ALU port. Each accepted request pushes the
// result expected for that requester's own operands onto the requester's
// scoreboard queue. Each consumed slot pops and compares. Scenario tasks
// additionally check grants, routing and handshake state inline.
// Expected lock-test grant order follows ALU_ARB_LOCK_EN.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [4*NUM_REQ-1:0]      req_ctrl;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [DATA_W*NUM_REQ-1:0] resp_data;
  logic [NUM_REQ-1:0]        resp_zero;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [3:0]                alu_ctrl;
  logic [DATA_W-1:0]         alu_result;
  logic                      alu_zero;
  logic [1:0]                grant_id;

  logic [3:0]  op_ctrl [NUM_REQ];
  logic [31:0] op_a    [NUM_REQ];
  logic [31:0] op_b    [NUM_REQ];
  logic [1:0]  last_grant;
  logic [32:0] alu_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [32:0] sb0 [$];
  logic [32:0] sb1 [$];

  assign req_ctrl = {op_ctrl[1], op_ctrl[0]};
  assign req_a    = {op_a[1], op_a[0]};
  assign req_b    = {op_b[1], op_b[0]};

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
    .req_a(req_a), .req_b(req_b), .req_lock(req_lock),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_zero(resp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .grant_id(grant_id)
  );

  // {zero, result} of an RV32I ALU
  function automatic logic [32:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (c)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = {31'b0, $signed(a) < $signed(b)};
      4'b0110: r = {31'b0, a < b};
      4'b0111: r = a << b[4:0];
      4'b1000: r = a >> b[4:0];
      4'b1001: r = $signed(a) >>> b[4:0];
      default: r = 32'h0;
    endcase
    return {(r == 32'h0), r};
  endfunction

  assign alu_out    = alu_model(alu_ctrl, alu_a, alu_b);
  assign alu_result = alu_out[31:0];
  assign alu_zero   = alu_out[32];

  // One clock: scoreboard pop for slots being consumed, push for requests
  // being accepted, then move to just after the next rising edge.
  task automatic advance();
    logic [32:0] exp;
    logic [32:0] got;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (resp_valid[i] && resp_ready[i]) begin
        got = {resp_zero[i], resp_data[i*DATA_W +: DATA_W]};
        tests_run++;
        if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
          tests_failed++;
          $display("FAIL sb_unexpected_slot%0d: got zero/data=%h, expected no pending result", i, got);
        end else begin
          exp = (i == 0) ? sb0.pop_front() : sb1.pop_front();
          if (got !== exp)
            begin tests_failed++; $display("FAIL sb_slot%0d: got zero/data=%h, expected %h", i, got, exp); end
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        if (i == 0) sb0.push_back(alu_model(op_ctrl[0], op_a[0], op_b[0]));
        else        sb1.push_back(alu_model(op_ctrl[1], op_a[1], op_b[1]));
      end
    end
    last_grant = req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    op_ctrl[0] = 4'h3; op_a[0] = 32'h1234; op_b[0] = 32'h55;
    op_ctrl[1] = 4'h4; op_a[1] = 32'h9999; op_b[1] = 32'h11;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_req_ready: got %b, expected 00", req_ready); end
    tests_run++;
    if (resp_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_resp_valid: got %b, expected 00", resp_valid); end
    tests_run++;
    if (resp_data !== 64'h0 || resp_zero !== 2'b00)
      begin tests_failed++; $display("FAIL reset_resp_data: got %h/%b, expected 0/00", resp_data, resp_zero); end
    tests_run++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_ctrl !== 4'h0 || grant_id !== 2'b00)
      begin tests_failed++; $display("FAIL reset_alu_idle: got a=%h b=%h ctrl=%h gid=%0d, expected 0 0 0 0", alu_a, alu_b, alu_ctrl, grant_id); end
    req_valid = 2'b00;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    op_ctrl[0] = 4'b0000; op_a[0] = 32'd5; op_b[0] = 32'd7;
    req_valid = 2'b01; resp_ready = 2'b00;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL single_grant: got %b, expected 01", req_ready); end
    tests_run++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_ctrl !== 4'h0 || grant_id !== 2'd0)
      begin tests_failed++; $display("FAIL single_alu_drive: got a=%0d b=%0d ctrl=%h gid=%0d, expected 5 7 0 0", alu_a, alu_b, alu_ctrl, grant_id); end
    advance();
    req_valid = 2'b00;
    #1;
    tests_run++;
    if (resp_valid !== 2'b01 || resp_data[31:0] !== 32'd12 || resp_zero[0] !== 1'b0)
      begin tests_failed++; $display("FAIL single_resp: got v=%b d=%0d z=%b, expected 01 12 0", resp_valid, resp_data[31:0], resp_zero[0]); end
    resp_ready = 2'b01;
    advance();
    resp_ready = 2'b00;
    tests_run++;
    if (resp_valid !== 2'b00) begin tests_failed++; $display("FAIL single_drain: got %b, expected 00", resp_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    req_valid = 2'b11; resp_ready = 2'b11; req_lock = 2'b00;
    // Pointer sits at 1 after the single-requester test.
    for (int k = 0; k < 8; k++) begin
      op_ctrl[0] = 4'(k);     op_a[0] = $urandom; op_b[0] = $urandom;
      op_ctrl[1] = 4'(k + 2); op_a[1] = $urandom; op_b[1] = $urandom;
      #1;
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      tests_run++;
      if (req_ready !== exp_g) begin tests_failed++; $display("FAIL contention_grant_%0d: got %b, expected %b", k, req_ready, exp_g); end
      tests_run++;
      if (alu_a !== ((k % 2 == 0) ? op_a[1] : op_a[0]) || grant_id !== ((k % 2 == 0) ? 2'd1 : 2'd0))
        begin tests_failed++; $display("FAIL contention_route_%0d: got a=%h gid=%0d", k, alu_a, grant_id); end
      advance();
    end
    req_valid = 2'b00;
    advance();
    advance();
    resp_ready = 2'b00;
    tests_run++;
    if (sb0.size() != 0 || sb1.size() != 0)
      begin tests_failed++; $display("FAIL contention_sb_empty: got %0d/%0d pending, expected 0/0", sb0.size(), sb1.size()); end
  endtask

  task automatic test_backpressure();
    op_ctrl[0] = 4'b0001; op_a[0] = 32'd3; op_b[0] = 32'd3;
    req_valid = 2'b01; resp_ready = 2'b00;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL bp_first_grant: got %b, expected 01", req_ready); end
    advance();
    op_ctrl[0] = 4'b0000; op_a[0] = 32'd1; op_b[0] = 32'd1;
    op_ctrl[1] = 4'b0100; op_a[1] = $urandom; op_b[1] = $urandom;
    req_valid = 2'b11; resp_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL bp_masked_%0d: got %b, expected 10", k, req_ready); end
      tests_run++;
      if (resp_valid[0] !== 1'b1 || resp_data[31:0] !== 32'd0 || resp_zero[0] !== 1'b1)
        begin tests_failed++; $display("FAIL bp_hold_%0d: got v=%b d=%h z=%b, expected 1 0 1", k, resp_valid[0], resp_data[31:0], resp_zero[0]); end
      advance();
    end
    resp_ready = 2'b11;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL bp_reload_grant: got %b, expected 01", req_ready); end
    advance();
    tests_run++;
    if (resp_valid[0] !== 1'b1 || resp_data[31:0] !== 32'd2 || resp_zero[0] !== 1'b0)
      begin tests_failed++; $display("FAIL bp_reload_data: got v=%b d=%0d z=%b, expected 1 2 0", resp_valid[0], resp_data[31:0], resp_zero[0]); end
    req_valid = 2'b00;
    advance();
    advance();
    resp_ready = 2'b00;
  endtask

  task automatic test_idle();
    req_valid = 2'b00; resp_ready = 2'b11;
    op_ctrl[0] = 4'h7; op_a[0] = 32'hdead_beef; op_b[0] = 32'h3;
    op_ctrl[1] = 4'h9; op_a[1] = 32'hcafe_f00d; op_b[1] = 32'h4;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (req_ready !== 2'b00 || alu_a !== 32'h0 || alu_b !== 32'h0 || alu_ctrl !== 4'h0 || grant_id !== 2'd0)
        begin tests_failed++; $display("FAIL idle_%0d: got rdy=%b a=%h b=%h ctrl=%h gid=%0d, expected 00 0 0 0 0", k, req_ready, alu_a, alu_b, alu_ctrl, grant_id); end
      advance();
    end
    // Pointer was left at 1 by the reload grant to requester 0.
    req_valid = 2'b11;
    #1;
    tests_run++;
    if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL idle_ptr_held: got %b, expected 10", req_ready); end
    advance();
    req_valid = 2'b00;
    advance();
    resp_ready = 2'b00;
  endtask

  task automatic test_lock();
    logic [1:0] exp_g;
    resp_ready = 2'b11;
    req_valid = 2'b01;
    advance();
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      req_lock = (k < 3) ? 2'b10 : 2'b00;
      op_a[0] = $urandom; op_a[1] = $urandom;
      #1;
`ifdef ALU_ARB_LOCK_EN
      exp_g = (k < 4) ? 2'b10 : 2'b01;
`else
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`endif
      tests_run++;
      if (req_ready !== exp_g) begin tests_failed++; $display("FAIL lock_grant_%0d: got %b, expected %b", k, req_ready, exp_g); end
      advance();
    end
    req_valid = 2'b00; req_lock = 2'b00;
    advance();
    advance();
    resp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    resp_ready = 2'b00;
    op_ctrl[0] = 4'h2; op_ctrl[1] = 4'h3;
    req_valid = 2'b10;
    #1;
    tests_run++;
    if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL rmid_fill1: got %b, expected 10", req_ready); end
    advance();
    req_valid = 2'b01;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL rmid_fill0: got %b, expected 01", req_ready); end
    advance();
    req_valid = 2'b11;
    #1;
    tests_run++;
    if (resp_valid !== 2'b11 || req_ready !== 2'b00)
      begin tests_failed++; $display("FAIL rmid_full: got v=%b rdy=%b, expected 11 00", resp_valid, req_ready); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (resp_valid !== 2'b00 || req_ready !== 2'b00 || alu_ctrl !== 4'h0 || resp_data !== 64'h0)
      begin tests_failed++; $display("FAIL rmid_async: got v=%b rdy=%b ctrl=%h d=%h, expected 00 00 0 0", resp_valid, req_ready, alu_ctrl, resp_data); end
    sb0.delete();
    sb1.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL rmid_first_grant: got %b, expected 01", req_ready); end
    advance();
    req_valid = 2'b00; resp_ready = 2'b11;
    advance();
    resp_ready = 2'b00;
    tests_run++;
    if (sb0.size() != 0 || sb1.size() != 0 || resp_valid !== 2'b00)
      begin tests_failed++; $display("FAIL rmid_drain: got %0d/%0d pending v=%b, expected 0/0 00", sb0.size(), sb1.size(), resp_valid); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = '0; req_lock = '0;
    for (int i = 0; i < NUM_REQ; i++) begin op_ctrl[i] = '0; op_a[i] = '0; op_b[i] = '0; end
    last_grant = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_idle();
    test_lock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
